// File: rtl/instr_seq.sv
// instr_seq: MSP430 multi-cycle instruction sequencer; define SEQ_WAITSTATE_EN to honour mem_rdy and the WAIT_MAX timeout
module instr_seq #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MDB_out,
  input  logic        mem_rdy,
  output logic [15:0] IR,
  output logic [2:0]  MAB_sel,
  output logic [1:0]  MPC,
  output logic        src_ext_ld,
  output logic        dst_ext_ld,
  output logic        autoinc,
  output logic        RW,
  output logic        MW,
  output logic        busy,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, SRC_EXT = 3'd2, SRC_RD = 3'd3,
                         DST_EXT = 3'd4, DST_RD = 3'd5, EXEC = 3'd6, DST_WR = 3'd7;
  logic [2:0]  state_q, state_d, nxt;
  logic [15:0] ir_q, ir_d, dec;
  logic        rdy, mem, stall, to, unused;
  logic        jmp, f1, f2, legal, opnd, ad, cg, imm, cmpbit, f2wr;
  logic        n_se, n_sr, n_de, n_dr, n_dw, wr_reg;
  logic [1:0]  as;
  logic [3:0]  rs;
  // Decode the word being fetched so the FETCH exit already knows the next phase
  assign dec    = (state_q == FETCH) ? MDB_out : ir_q;
  assign jmp    = dec[15:13] == 3'b001;
  assign f2     = dec[15:12] == 4'b0001;
  assign f1     = dec[15:12] >= 4'b0100;
  assign legal  = jmp | f1 | f2;
  assign opnd   = f1 | f2;
  assign as     = dec[5:4];
  assign rs     = f1 ? dec[11:8] : dec[3:0];
  assign ad     = f1 & dec[7];
  assign cg     = (rs == 4'd3) | (rs == 4'd2 & as[1]);
  assign imm    = (as == 2'd3) & (rs == 4'd0);
  assign cmpbit = (dec[15:12] == 4'b1001) | (dec[15:12] == 4'b1011);
  assign f2wr   = f2 & (dec[9:7] <= 3'd3);
  assign n_se   = opnd & ~cg & ((as == 2'd1) | imm);
  assign n_sr   = opnd & (as != 2'd0) & ~imm & ~cg;
  assign n_de   = ad;
  assign n_dr   = ad & (dec[15:12] != 4'b0100);
  assign n_dw   = (ad & ~cmpbit) | (f2wr & n_sr);
  assign wr_reg = (f1 & ~ad & ~cmpbit) | (f2wr & (as == 2'd0));
  assign mem    = (state_q != IDLE) & (state_q != EXEC);
  assign stall  = mem & ~rdy;
`ifdef SEQ_WAITSTATE_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign rdy    = mem_rdy;
  assign to     = stall & (cnt_q == CW'(WAIT_MAX - 1));
  assign cnt_d  = (stall & ~to) ? cnt_q + 1'b1 : '0;
  assign unused = dec[6];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign rdy    = 1'b1;
  assign to     = 1'b0;
  assign unused = ^{dec[6], mem_rdy} ^ (WAIT_MAX > 0);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  // Phases are numbered in execution order, so the next phase is the first needed one above the current
  always_comb begin
    nxt = (state_q < SRC_EXT && n_se) ? SRC_EXT :
          (state_q < SRC_RD  && n_sr) ? SRC_RD  :
          (state_q < DST_EXT && n_de) ? DST_EXT :
          (state_q < DST_RD  && n_dr) ? DST_RD  :
          (state_q < EXEC)            ? EXEC    :
          (state_q < DST_WR  && n_dw) ? DST_WR  : FETCH;
    state_d = (state_q == IDLE || to) ? FETCH : stall ? state_q : nxt;
    ir_d    = (state_q == FETCH && !stall) ? MDB_out : ir_q;
  end
  always_comb begin
    MAB_sel    = (state_q == SRC_RD) ? (as[1] ? 3'd1 : 3'd2) :
                 (state_q == DST_RD || state_q == DST_WR) ? 3'd2 : 3'd0;
    MPC        = ((state_q == FETCH || state_q == SRC_EXT || state_q == DST_EXT) && rdy) ? 2'd1 :
                 (state_q == EXEC && jmp) ? 2'd3 : 2'd0;
    src_ext_ld = (state_q == SRC_EXT) & rdy;
    dst_ext_ld = (state_q == DST_EXT) & rdy;
    autoinc    = (state_q == SRC_RD) & rdy & (as == 2'd3);
    RW         = (state_q == EXEC) & wr_reg;
    MW         = (state_q == DST_WR) & rdy;
    busy       = state_q != IDLE;
    illegal    = (state_q == EXEC) & ~legal;
    bus_err    = to;
    state      = state_q;
    IR         = ir_q;
  end
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: directed and random checks of instr_seq against a phase-queue reference model
module tb_instr_seq;
  localparam int WAIT_MAX = 16;
  localparam int IDLE = 0, FETCH = 1, SE = 2, SR = 3, DE = 4, DR = 5, EX = 6, DW = 7;
  logic        clk = 0, rst_n = 0, rdy = 1;
  logic [15:0] mdb = 16'h4A0B;
  logic [15:0] IR;
  logic [2:0]  MAB_sel, state;
  logic [1:0]  MPC;
  logic        src_ext_ld, dst_ext_ld, autoinc, RW, MW, busy, illegal, bus_err;
  logic [12:0] outs;
  int          checks = 0, errors = 0;
  instr_seq #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .MDB_out(mdb), .mem_rdy(rdy), .IR(IR), .MAB_sel(MAB_sel),
    .MPC(MPC), .src_ext_ld(src_ext_ld), .dst_ext_ld(dst_ext_ld), .autoinc(autoinc), .RW(RW),
    .MW(MW), .busy(busy), .illegal(illegal), .bus_err(bus_err), .state(state)
  );
  always #5 clk = ~clk;
  assign outs = {MAB_sel, MPC, src_ext_ld, dst_ext_ld, autoinc, RW, MW, busy, illegal, bus_err};
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  task automatic want(input string nm, input int st, input logic [15:0] ir, input logic [12:0] o);
    chk({nm, "/state"}, state, st);
    chk({nm, "/IR"}, IR, ir);
    chk({nm, "/outs"}, outs, o);
  endtask
  task automatic step(input logic [15:0] m, input logic r);
    @(posedge clk); #1;
    mdb = m;
    rdy = r;
    @(negedge clk);
  endtask
  // Instruction rules, stated directly from the ISA description
  function automatic bit has_opnd(input logic [15:0] w);
    return w[15:12] == 4'd1 || w[15:12] >= 4'd4;
  endfunction
  function automatic bit is_legal(input logic [15:0] w);
    return has_opnd(w) || w[15:13] == 3'd1;
  endfunction
  function automatic int src_reg(input logic [15:0] w);
    return w[15:12] >= 4'd4 ? int'(w[11:8]) : int'(w[3:0]);
  endfunction
  function automatic bit is_cg(input logic [15:0] w);
    return src_reg(w) == 3 || (src_reg(w) == 2 && w[5:4] >= 2);
  endfunction
  function automatic bit is_imm(input logic [15:0] w);
    return w[5:4] == 3 && src_reg(w) == 0;
  endfunction
  function automatic bit needs_ext(input logic [15:0] w);
    return has_opnd(w) && !is_cg(w) && (w[5:4] == 1 || is_imm(w));
  endfunction
  function automatic bit needs_rd(input logic [15:0] w);
    return has_opnd(w) && w[5:4] != 0 && !is_imm(w) && !is_cg(w);
  endfunction
  function automatic bit dst_mem(input logic [15:0] w);
    return w[15:12] >= 4'd4 && w[7];
  endfunction
  function automatic bit tests_only(input logic [15:0] w);
    return w[15:12] == 4'd9 || w[15:12] == 4'd11;
  endfunction
  function automatic bit single_rw(input logic [15:0] w);
    return w[15:12] == 4'd1 && w[9:7] <= 3;
  endfunction
  function automatic bit writes_reg(input logic [15:0] w);
    return (w[15:12] >= 4'd4 && !w[7] && !tests_only(w)) || (single_rw(w) && w[5:4] == 0);
  endfunction
  function automatic bit writes_mem(input logic [15:0] w);
    return (dst_mem(w) && !tests_only(w)) || (single_rw(w) && needs_rd(w));
  endfunction
  int          ph = IDLE, m_wait = 0;
  logic [15:0] m_ir = '0;
  int          q[$];
  function automatic void plan(input logic [15:0] w);
    q.delete();
    if (needs_ext(w)) q.push_back(SE);
    if (needs_rd(w)) q.push_back(SR);
    if (dst_mem(w)) q.push_back(DE);
    if (dst_mem(w) && w[15:12] != 4'd4) q.push_back(DR);
    q.push_back(EX);
    if (writes_mem(w)) q.push_back(DW);
  endfunction
  always @(negedge rst_n) begin
    ph = IDLE;
    m_ir = '0;
    m_wait = 0;
    q.delete();
  end
  always @(negedge clk) begin : model
    logic r, stall;
    logic [12:0] e;
`ifdef SEQ_WAITSTATE_EN
    r = rdy;
`else
    r = 1'b1;
`endif
    stall = ph != IDLE && ph != EX && !r;
    e[12:10] = ph == SR ? (m_ir[5:4] >= 2 ? 3'd1 : 3'd2) : (ph == DR || ph == DW) ? 3'd2 : 3'd0;
    e[9:8]   = (!stall && (ph == FETCH || ph == SE || ph == DE)) ? 2'd1 :
               (ph == EX && m_ir[15:13] == 3'd1) ? 2'd3 : 2'd0;
    e[7] = ph == SE && r;
    e[6] = ph == DE && r;
    e[5] = ph == SR && r && m_ir[5:4] == 3;
    e[4] = ph == EX && writes_reg(m_ir);
    e[3] = ph == DW && r;
    e[2] = ph != IDLE;
    e[1] = ph == EX && !is_legal(m_ir);
    e[0] = stall && m_wait == WAIT_MAX - 1;
    chk("model/state", state, ph);
    chk("model/IR", IR, m_ir);
    chk("model/outs", outs, e);
    if (rst_n) begin
      if (ph == IDLE) ph = FETCH;
      else if (stall) begin
        m_wait++;
        if (m_wait == WAIT_MAX) begin
          ph = FETCH;
          m_wait = 0;
          q.delete();
        end
      end else begin
        m_wait = 0;
        if (ph == FETCH) begin
          m_ir = mdb;
          plan(mdb);
        end
        ph = q.size() > 0 ? q.pop_front() : FETCH;
      end
    end
  end
  initial begin
    int burst;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    want("idle", IDLE, 16'h0, 13'b000_00_00000000);
    step(16'h4A0B, 1); want("mov_fetch", FETCH, 16'h0,    13'b000_01_00000100);
    step(16'h403F, 1); want("mov_exec",  EX,    16'h4A0B, 13'b000_00_00010100);
    step(16'h403F, 1); want("imm_fetch", FETCH, 16'h4A0B, 13'b000_01_00000100);
    step(16'h1234, 1); want("imm_ext",   SE,    16'h403F, 13'b000_01_10000100);
    step(16'h5A95, 1); want("imm_exec",  EX,    16'h403F, 13'b000_00_00010100);
    step(16'h5A95, 1); want("add_fetch", FETCH, 16'h403F, 13'b000_01_00000100);
    step(16'h1111, 1); want("add_sext",  SE,    16'h5A95, 13'b000_01_10000100);
    step(16'h2222, 1); want("add_srd",   SR,    16'h5A95, 13'b010_00_00000100);
    step(16'h3333, 1); want("add_dext",  DE,    16'h5A95, 13'b000_01_01000100);
    step(16'h0000, 1); want("add_drd",   DR,    16'h5A95, 13'b010_00_00000100);
    step(16'h0000, 1); want("add_exec",  EX,    16'h5A95, 13'b000_00_00000100);
    step(16'h2C05, 1); want("add_dwr",   DW,    16'h5A95, 13'b010_00_00001100);
    step(16'h2C05, 1); want("jc_fetch",  FETCH, 16'h5A95, 13'b000_01_00000100);
    step(16'h0000, 1); want("jc_exec",   EX,    16'h2C05, 13'b000_11_00000100);
    step(16'h0000, 1); want("ill_fetch", FETCH, 16'h2C05, 13'b000_01_00000100);
    step(16'h5A95, 1); want("ill_exec",  EX,    16'h0000, 13'b000_00_00000110);
    step(16'h5A95, 1); want("ill_back",  FETCH, 16'h0000, 13'b000_01_00000100);
    step(16'h1111, 1); want("r_sext",    SE,    16'h5A95, 13'b000_01_10000100);
    step(16'h2222, 1); want("r_srd",     SR,    16'h5A95, 13'b010_00_00000100);
    step(16'h3333, 1); want("r_dext",    DE,    16'h5A95, 13'b000_01_01000100);
    step(16'h4A0B, 1); want("r_drd",     DR,    16'h5A95, 13'b010_00_00000100);
    #1 rst_n = 0;
    #1 want("rst_mid", IDLE, 16'h0, 13'b000_00_00000000);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    want("rst_idle", IDLE, 16'h0, 13'b000_00_00000000);
    step(16'h4A0B, 1); want("rst_fetch", FETCH, 16'h0,    13'b000_01_00000100);
    step(16'h4A0B, 1); want("rst_exec",  EX,    16'h4A0B, 13'b000_00_00010100);
`ifdef SEQ_WAITSTATE_EN
    for (int i = 1; i <= WAIT_MAX; i++) begin
      step(16'h403F, 0);
      want($sformatf("wait%0d", i), FETCH, 16'h4A0B, i == WAIT_MAX ? 13'b000_00_00000101 : 13'b000_00_00000100);
    end
    for (int i = 1; i <= 3; i++) begin
      step(16'h403F, 0);
      want($sformatf("short%0d", i), FETCH, 16'h4A0B, 13'b000_00_00000100);
    end
    step(16'h403F, 1); want("short_go",  FETCH, 16'h4A0B, 13'b000_01_00000100);
    step(16'h1234, 1); want("short_ext", SE,    16'h403F, 13'b000_01_10000100);
`else
    step(16'h403F, 0); want("nowait_fetch", FETCH, 16'h4A0B, 13'b000_01_00000100);
    step(16'h1234, 0); want("nowait_ext",   SE,    16'h403F, 13'b000_01_10000100);
`endif
    step(16'h4A0B, 1); want("post_exec", EX, 16'h403F, 13'b000_00_00010100);
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      mdb = 16'($urandom);
      if (burst > 0) begin
        rdy = 0;
        burst--;
      end else if ($urandom_range(0, 99) == 0) begin
        burst = $urandom_range(12, 20);
        rdy = 0;
      end else rdy = $urandom_range(0, 4) != 0;
      if (i == 1500) rst_n = 0;
      if (i == 1503) rst_n = 1;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
